// File: rtl/operand_vector_loader.sv
// operand_vector_loader
// Packs a stream of (a, b) element pairs into flat vector buses for the
// dot-product datapath. Two vector slots form a ping-pong FIFO: one slot
// is being filled while the other holds a finished vector for the consumer.
// Element i of a vector sits at bits [i*W +: W], so element 0 is in the LSBs.
module operand_vector_loader #(
  parameter int DIM          = 10,
  parameter int A_DATA_WIDTH = 16,
  parameter int B_DATA_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [A_DATA_WIDTH-1:0]     in_a,
  input  logic [B_DATA_WIDTH-1:0]     in_b,
  input  logic                        in_last,
  output logic [A_DATA_WIDTH*DIM-1:0] a,
  output logic [B_DATA_WIDTH*DIM-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        last_error
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int AW    = A_DATA_WIDTH * DIM;
  localparam int BW    = B_DATA_WIDTH * DIM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  // Slot storage and bookkeeping
  logic [AW-1:0]    slot_a [2];
  logic [BW-1:0]    slot_b [2];
  logic [1:0]       full;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [IDX_W-1:0] fill_idx;
  logic             last_err_q;

  // Per-cycle decisions
  logic             accept;
  logic             at_last_idx;
  logic             complete;
  logic             handoff;
  logic [1:0]       count;
  logic [1:0]       full_next;
  logic [AW-1:0]    fill_a_next;
  logic [BW-1:0]    fill_b_next;

  // Occupancy and handshake decode; in_ready depends only on registered state
  always_comb begin
    count       = {1'b0, full[0]} + {1'b0, full[1]};
    in_ready    = (count < 2'd2);
    out_valid   = (count != 2'd0);
    accept      = in_valid && in_ready;
    at_last_idx = (fill_idx == LAST_IDX);
    complete    = accept && (in_last || at_last_idx);
    handoff     = out_valid && out_ready;
  end

  // Next contents of the slot being filled; starting a fresh vector clears
  // the slot so lanes beyond a short vector's end read as zero
  always_comb begin
    fill_a_next = (fill_idx == '0) ? '0 : slot_a[wr_ptr];
    fill_b_next = (fill_idx == '0) ? '0 : slot_b[wr_ptr];
    fill_a_next[int'(fill_idx)*A_DATA_WIDTH +: A_DATA_WIDTH] = in_a;
    fill_b_next[int'(fill_idx)*B_DATA_WIDTH +: B_DATA_WIDTH] = in_b;
  end

  // Slot full flags: completion marks the write slot, handoff frees the read
  // slot. Both can never target the same slot: that would need count==2,
  // which blocks acceptance.
  always_comb begin
    full_next = full;
    if (handoff) begin
      full_next[rd_ptr] = 1'b0;
    end
    if (complete) begin
      full_next[wr_ptr] = 1'b1;
    end
  end

  // Fill index, slot pointers, occupancy and sticky error register
  always_ff @(posedge clock) begin
    if (reset) begin
      full       <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fill_idx   <= '0;
      last_err_q <= 1'b0;
    end else begin
      full <= full_next;
      if (accept) begin
        if (complete) begin
          fill_idx <= '0;
          wr_ptr   <= ~wr_ptr;
        end else begin
          fill_idx <= fill_idx + IDX_W'(1);
        end
        if (at_last_idx && !in_last) begin
          last_err_q <= 1'b1;
        end
      end
      if (handoff) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Slot data: only the write slot is ever updated, so the slot being
  // presented stays stable while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_a[0] <= '0;
      slot_a[1] <= '0;
      slot_b[0] <= '0;
      slot_b[1] <= '0;
    end else if (accept) begin
      slot_a[wr_ptr] <= fill_a_next;
      slot_b[wr_ptr] <= fill_b_next;
    end
  end

  // Output buses show the read slot only while a vector is valid
  always_comb begin
    a          = out_valid ? slot_a[rd_ptr] : '0;
    b          = out_valid ? slot_b[rd_ptr] : '0;
    last_error = last_err_q;
  end

endmodule

// File: tb/tb_operand_vector_loader.sv
// Bench for operand_vector_loader: directed scenarios plus a randomized
// phase, all checked every cycle against a queue-based vector model.
module tb_operand_vector_loader;

  localparam int DIM = 10;
  localparam int EW  = 16;
  localparam int AW  = EW * DIM;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [EW-1:0] in_a = '0;
  logic [EW-1:0] in_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          last_error;
  logic [AW-1:0] a;
  logic [AW-1:0] b;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;

  always #5 clock = ~clock;

  operand_vector_loader #(.DIM(DIM), .A_DATA_WIDTH(EW), .B_DATA_WIDTH(EW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .last_error(last_error)
  );

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: a FIFO of finished vectors (max 2) plus a partial vector
  typedef struct packed {
    logic [AW-1:0] va;
    logic [AW-1:0] vb;
  } vec_t;

  vec_t          q[$];
  logic [AW-1:0] pa;
  logic [AW-1:0] pb;
  int            n = 0;
  bit            err = 1'b0;
  bit            model_live = 1'b0;
  logic [EW-1:0] handoff_log[$];

  always @(posedge clock) begin
    bit acc;
    bit ho;
    if (reset) begin
      q.delete();
      n = 0;
      err = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      acc = in_valid && (q.size() < 2);
      ho  = (q.size() > 0) && out_ready;
      if (ho) void'(q.pop_front());
      if (acc) begin
        if (n == 0) begin
          pa = '0;
          pb = '0;
        end
        pa[n*EW +: EW] = in_a;
        pb[n*EW +: EW] = in_b;
        n++;
        if (in_last || n == DIM) begin
          if (!in_last) err = 1'b1;
          q.push_back('{va: pa, vb: pb});
          n = 0;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clock) begin
    if (model_live) begin
      chk("in_ready", AW'(in_ready), AW'(q.size() < 2));
      chk("out_valid", AW'(out_valid), AW'(q.size() > 0));
      chk("a_bus", a, (q.size() > 0) ? q[0].va : '0);
      chk("b_bus", b, (q.size() > 0) ? q[0].vb : '0);
      chk("last_error", AW'(last_error), AW'(err));
      if (out_valid && out_ready && !reset) handoff_log.push_back(a[EW-1:0]);
    end
  end

  function automatic logic [AW-1:0] mk(input int base, input int step);
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) v[i*EW +: EW] = EW'(base + i * step);
    return v;
  endfunction

  function automatic int dot(input logic [AW-1:0] x, input logic [AW-1:0] y);
    int s;
    s = 0;
    for (int i = 0; i < DIM; i++) s += int'(x[i*EW +: EW]) * int'(y[i*EW +: EW]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold a pair until it is accepted; stalled cycles are counted
  task automatic send_pair(input int va, input int vb, input bit last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_a = EW'(va);
    in_b = EW'(vb);
    in_last = last;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
      stall_cnt++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_vec(input int abase, input int bbase, input int step, input int len, input bit last);
    for (int i = 0; i < len; i++) send_pair(abase + i * step, bbase + i * step, last && (i == len - 1));
  endtask

  initial begin
    logic [AW-1:0] ea;
    logic [AW-1:0] eb;
    #1;
    // 1: reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", AW'(out_valid), AW'(0));
    chk("rst_a", a, '0);
    chk("rst_b", b, '0);
    chk("rst_last_error", AW'(last_error), AW'(0));
    chk("rst_in_ready", AW'(in_ready), AW'(1));

    // 2: ten (8,8) pairs
    out_ready = 1'b1;
    send_vec(8, 8, 0, DIM, 1'b1);
    chk("t2_out_valid", AW'(out_valid), AW'(1));
    chk("t2_a", a, mk(8, 0));
    chk("t2_b", b, mk(8, 0));
    chk("t2_dot", AW'(dot(a, b)), AW'(640));

    // throughput: back-to-back vectors with the consumer always ready
    stall_cnt = 0;
    send_vec(16'h0010, 16'h0020, 1, DIM, 1'b1);
    send_vec(16'h0030, 16'h0040, 1, DIM, 1'b1);
    send_vec(16'h0050, 16'h0060, 1, 3, 1'b1);
    chk("throughput_stalls", AW'(stall_cnt), AW'(0));
    tick();
    tick();

    // 3: consumer stalled, three full vectors
    handoff_log.delete();
    out_ready = 1'b0;
    send_vec(16'h0100, 16'h1100, 1, DIM, 1'b1);
    chk("t3_first_a", a, mk(16'h0100, 1));
    send_vec(16'h0200, 16'h1200, 1, DIM, 1'b1);
    chk("t3_in_ready_full", AW'(in_ready), AW'(0));
    repeat (4) tick();
    chk("t3_a_stable", a, mk(16'h0100, 1));
    chk("t3_b_stable", b, mk(16'h1100, 1));
    fork
      send_vec(16'h0300, 16'h1300, 1, DIM, 1'b1);
      begin
        repeat (6) tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("t3_drain_count", AW'(handoff_log.size()), AW'(3));
    if (handoff_log.size() >= 3) begin
      chk("t3_order1", AW'(handoff_log[0]), AW'(16'h0100));
      chk("t3_order2", AW'(handoff_log[1]), AW'(16'h0200));
      chk("t3_order3", AW'(handoff_log[2]), AW'(16'h0300));
    end

    // 4: short vector
    out_ready = 1'b0;
    send_vec(1, 5, 1, 4, 1'b1);
    ea = '0;
    eb = '0;
    for (int i = 0; i < 4; i++) begin
      ea[i*EW +: EW] = EW'(1 + i);
      eb[i*EW +: EW] = EW'(5 + i);
    end
    chk("t4_a", a, ea);
    chk("t4_b", b, eb);
    chk("t4_last_error", AW'(last_error), AW'(0));
    out_ready = 1'b1;
    tick();
    tick();

    // 5: full vector without in_last
    send_vec(16'h0500, 16'h0600, 1, DIM, 1'b0);
    chk("t5_out_valid", AW'(out_valid), AW'(1));
    chk("t5_a", a, mk(16'h0500, 1));
    chk("t5_last_error", AW'(last_error), AW'(1));
    send_vec(2, 3, 1, DIM, 1'b1);
    send_vec(4, 5, 1, 6, 1'b1);
    tick();
    chk("t5_sticky", AW'(last_error), AW'(1));

    // 6: partial vector discarded by reset
    send_vec(7, 7, 0, 5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_partial", AW'(out_valid), AW'(0));
      tick();
    end
    chk("t6_err_cleared", AW'(last_error), AW'(0));
    send_vec(1, 1, 0, DIM, 1'b1);
    chk("t6_a_ones", a, mk(1, 0));
    chk("t6_b_ones", b, mk(1, 0));
    tick();

    // randomized phase with varying consumer back-pressure
    for (int blk = 0; blk < 15; blk++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_a      = EW'($urandom);
        in_b      = EW'($urandom);
        in_last   = ($urandom_range(0, 5) == 0);
        out_ready = ($urandom_range(0, 3) < bias) || (bias == 3);
        reset     = ($urandom_range(0, 599) == 0);
        tick();
      end
    end
    in_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
